// File: rtl/rv_delay_line_param_if.sv
// Ready/valid channel carrying one WIDTH-bit payload per beat.
//   data  : payload, driven by the producer
//   valid : producer has a beat on data
//   ready : consumer accepts the beat this cycle
// master = producer side, slave = consumer side.
interface rv_delay_line_param_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] data;
    logic             valid;
    logic             ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/rv_delay_line_param.sv
// Parametrised ready/valid delay line: DEPTH forward-registered stages of
// WIDTH bits, minimum latency DEPTH cycles, 1 beat/cycle sustained.
// Ready is combinational back through the chain; valid/data are registered.
// Optional fill-level monitor enabled by defining RV_DELAY_LEVEL_EN.
// Ports:
//   clock_port  : clock, rising edge
//   reset_port  : synchronous active-low reset
//   flush       : synchronous clear of all stage valids (data held)
//   input_port  : upstream channel (slave modport)
//   output_port : downstream channel (master modport)
//   level/empty/full : registered fill level and its decodes (RV_DELAY_LEVEL_EN)
module rv_delay_line_param #(
    parameter int unsigned      WIDTH      = 8,
    parameter int unsigned      DEPTH      = 5,
    parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
    input  logic                         clock_port,
    input  logic                         reset_port,
    input  logic                         flush,
    rv_delay_line_param_if.slave         input_port,
    rv_delay_line_param_if.master        output_port
`ifdef RV_DELAY_LEVEL_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         empty,
    output logic                         full
`endif
);

    logic [DEPTH-1:0] v;
    logic [WIDTH-1:0] d   [DEPTH];
    logic [DEPTH-1:0] vin;
    logic [WIDTH-1:0] din [DEPTH];
    // rdy[i] is ready into stage i; rdy[DEPTH] is the downstream ready
    logic [DEPTH:0]   rdy;

    assign rdy[DEPTH] = output_port.ready;

    // Per-stage ready chain and stage input selection
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        assign rdy[i] = ~v[i] | rdy[i+1];
        if (i == 0) begin : g_head
            assign vin[i] = input_port.valid;
            assign din[i] = input_port.data;
        end else begin : g_body
            assign vin[i] = v[i-1];
            assign din[i] = d[i-1];
        end
    end

    // Flush blocks transfers on both sides for the cycle it is asserted
    assign input_port.ready  = rdy[0] & ~flush;
    assign output_port.valid = v[DEPTH-1] & ~flush;
    assign output_port.data  = d[DEPTH-1];

    // Stage registers: data loads only on accept, valid clears on hand-off
    always_ff @(posedge clock_port) begin
        if (!reset_port) begin
            v <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                d[i] <= RESET_DATA;
            end
        end else if (flush) begin
            v <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (vin[i] && rdy[i]) begin
                    d[i] <= din[i];
                    v[i] <= 1'b1;
                end else if (rdy[i+1] && v[i]) begin
                    v[i] <= 1'b0;
                end
            end
        end
    end

`ifdef RV_DELAY_LEVEL_EN
    localparam int unsigned LVL_W = $clog2(DEPTH + 1);

    logic             in_acc_c;
    logic             out_xfer_c;
    logic [LVL_W-1:0] level_nxt;

    assign in_acc_c   = input_port.valid & input_port.ready;
    assign out_xfer_c = output_port.valid & output_port.ready;

    // Next fill level from the two handshakes
    always_comb begin
        level_nxt = level;
        if (in_acc_c && !out_xfer_c) begin
            level_nxt = level + LVL_W'(1);
        end else if (!in_acc_c && out_xfer_c) begin
            level_nxt = level - LVL_W'(1);
        end
    end

    // Level and its decodes registered together so they never disagree
    always_ff @(posedge clock_port) begin
        if (!reset_port || flush) begin
            level <= '0;
            empty <= 1'b1;
            full  <= 1'b0;
        end else begin
            level <= level_nxt;
            empty <= (level_nxt == '0);
            full  <= (level_nxt == LVL_W'(DEPTH));
        end
    end
`endif

endmodule

// File: tb/tb_rv_delay_line_param.sv
// Self-checking bench for rv_delay_line_param (WIDTH=8, DEPTH=4).
module tb_rv_delay_line_param;

    localparam int unsigned W = 8;
    localparam int unsigned D = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;
`ifdef RV_DELAY_LEVEL_EN
    logic [2:0] level;
    logic       empty;
    logic       full;
`endif

    rv_delay_line_param_if #(.WIDTH(W)) in_if ();
    rv_delay_line_param_if #(.WIDTH(W)) out_if ();

    rv_delay_line_param #(
        .WIDTH      (W),
        .DEPTH      (D),
        .RESET_DATA (8'h00)
    ) dut (
        .clock_port  (clk),
        .reset_port  (rst_n),
        .flush       (flush),
        .input_port  (in_if),
        .output_port (out_if)
`ifdef RV_DELAY_LEVEL_EN
        ,
        .level       (level),
        .empty       (empty),
        .full        (full)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    // Behavioural model: ordered beats with the stage index each occupies.
    // A beat with k older beats ahead of it moves forward iff there is an
    // empty slot somewhere ahead of it, or the downstream is ready.
    typedef struct {
        logic [7:0] data;
        int         pos;
    } beat_t;
    beat_t mq[$];

    // Observations of the last cycle
    logic       s_ir, s_ov, s_acc;
    logic [7:0] s_od;
    int         s_lvl;
    int         s_cyc;
    logic [7:0] out_log[$];
    int         out_cyc[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic cycle(input logic r, input logic fl, input logic iv,
                         input logic [7:0] id, input logic ordy);
        logic m_ov, m_ir;
        int   n;
        @(negedge clk);
        rst_n        = r;
        flush        = fl;
        in_if.valid  = iv;
        in_if.data   = id;
        out_if.ready = ordy;
        #1;
        s_ir  = in_if.ready;
        s_ov  = out_if.valid;
        s_od  = out_if.data;
        s_cyc = cyc;
`ifdef RV_DELAY_LEVEL_EN
        s_lvl = int'(level);
`else
        s_lvl = 0;
`endif
        n    = mq.size();
        m_ov = !fl && n > 0 && mq[0].pos == D - 1;
        m_ir = !fl && (n < D || ordy);
        if (chk_en) begin
            chk("in_ready", 32'(s_ir), 32'(m_ir));
            chk("out_valid", 32'(s_ov), 32'(m_ov));
            if (m_ov) chk("out_data", 32'(s_od), 32'(mq[0].data));
`ifdef RV_DELAY_LEVEL_EN
            chk("level", 32'(level), 32'(n));
            chk("empty", 32'(empty), 32'(n == 0));
            chk("full", 32'(full), 32'(n == D));
`endif
        end
        s_acc = iv & s_ir;
        if (s_ov && ordy) begin
            out_log.push_back(s_od);
            out_cyc.push_back(cyc);
        end
        @(posedge clk);
        // Advance the model across this edge
        if (!r || fl) begin
            mq.delete();
        end else begin
            logic of, inf;
            of  = n > 0 && mq[0].pos == D - 1 && ordy;
            inf = iv && (n < D || ordy);
            for (int k = 0; k < n; k++) begin
                if (k < D - 1 - mq[k].pos || ordy) mq[k].pos++;
            end
            if (of) void'(mq.pop_front());
            if (inf) mq.push_back('{data: id, pos: 0});
        end
        if (!r) chk_en = 1'b1;
        cyc++;
    endtask

    typedef struct {
        logic       iv;
        logic [7:0] id;
        logic       ordy;
        logic       e_ir;
        logic       e_ov;
        logic [7:0] e_od;
        int         e_lvl;
    } vec_t;

    vec_t vt[13];

    initial begin
        int base, acc1, acc55;
        logic       r_iv;
        logic [7:0] r_id;
        logic       pend;

        rst_n = 1'b0; flush = 1'b0;
        in_if.valid = 1'b0; in_if.data = '0; out_if.ready = 1'b0;

        // Backpressure then release, from empty: 4 accepted, then 1-in/1-out
        vt[0]  = '{1'b1, 8'hA0, 1'b0, 1'b1, 1'b0, 8'h00, 0};
        vt[1]  = '{1'b1, 8'hA1, 1'b0, 1'b1, 1'b0, 8'h00, 1};
        vt[2]  = '{1'b1, 8'hA2, 1'b0, 1'b1, 1'b0, 8'h00, 2};
        vt[3]  = '{1'b1, 8'hA3, 1'b0, 1'b1, 1'b0, 8'h00, 3};
        vt[4]  = '{1'b1, 8'hA4, 1'b0, 1'b0, 1'b1, 8'hA0, 4};
        vt[5]  = '{1'b1, 8'hA4, 1'b0, 1'b0, 1'b1, 8'hA0, 4};
        vt[6]  = '{1'b1, 8'hA4, 1'b1, 1'b1, 1'b1, 8'hA0, 4};
        vt[7]  = '{1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 8'hA1, 4};
        vt[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA2, 4};
        vt[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA3, 3};
        vt[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA4, 2};
        vt[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA5, 1};
        vt[12] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 0};

        // Reset hold then release
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        chk("rst_out_valid", 32'(s_ov), 32'd0);
        chk("rst_out_data", 32'(s_od), 32'h00);
        chk("rst_in_ready", 32'(s_ir), 32'd1);
`ifdef RV_DELAY_LEVEL_EN
        chk("rst_level", 32'(s_lvl), 32'd0);
`endif

        // Table-driven backpressure / full pass-through
        foreach (vt[i]) begin
            cycle(1'b1, 1'b0, vt[i].iv, vt[i].id, vt[i].ordy);
            chk("vec_in_ready", 32'(s_ir), 32'(vt[i].e_ir));
            chk("vec_out_valid", 32'(s_ov), 32'(vt[i].e_ov));
            if (vt[i].e_ov) chk("vec_out_data", 32'(s_od), 32'(vt[i].e_od));
`ifdef RV_DELAY_LEVEL_EN
            chk("vec_level", 32'(s_lvl), 32'(vt[i].e_lvl));
`endif
        end

        // Streaming 0x01..0x10 back-to-back
        base = out_log.size();
        acc1 = -1;
        for (int k = 1; k <= 16; k++) begin
            cycle(1'b1, 1'b0, 1'b1, 8'(k), 1'b1);
            if (k == 1 && s_acc) acc1 = s_cyc;
        end
        for (int k = 0; k < 6; k++) cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        chk("stream_count", 32'(out_log.size() - base), 32'd16);
        if (out_log.size() - base == 16) begin
            chk("stream_latency", 32'(out_cyc[base] - acc1), 32'd4);
            chk("stream_span", 32'(out_cyc[base+15] - out_cyc[base]), 32'd15);
            for (int j = 0; j < 16; j++) chk("stream_order", 32'(out_log[base+j]), 32'(j + 1));
        end

        // Flush mid-stream
        base = out_log.size();
        cycle(1'b1, 1'b0, 1'b1, 8'h31, 1'b1);
        cycle(1'b1, 1'b0, 1'b1, 8'h32, 1'b1);
        cycle(1'b1, 1'b0, 1'b1, 8'h33, 1'b1);
        cycle(1'b1, 1'b1, 1'b1, 8'h34, 1'b1);
        chk("flush_in_ready", 32'(s_ir), 32'd0);
        chk("flush_out_valid", 32'(s_ov), 32'd0);
        cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        chk("post_flush_valid", 32'(s_ov), 32'd0);
`ifdef RV_DELAY_LEVEL_EN
        chk("post_flush_level", 32'(s_lvl), 32'd0);
`endif
        acc55 = -1;
        cycle(1'b1, 1'b0, 1'b1, 8'h55, 1'b1);
        if (s_acc) acc55 = s_cyc;
        for (int k = 0; k < 6; k++) cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        chk("flush_emitted", 32'(out_log.size() - base), 32'd1);
        if (out_log.size() - base == 1) begin
            chk("flush_next_data", 32'(out_log[base]), 32'h55);
            chk("flush_next_latency", 32'(out_cyc[base] - acc55), 32'd4);
        end

        // Reset mid-operation with a full, stalled chain
        base = out_log.size();
        for (int k = 0; k < 4; k++) cycle(1'b1, 1'b0, 1'b1, 8'(8'h11 + k), 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("rst_mid_valid", 32'(s_ov), 32'd0);
        chk("rst_mid_data", 32'(s_od), 32'h00);
        chk("rst_mid_in_ready", 32'(s_ir), 32'd1);
`ifdef RV_DELAY_LEVEL_EN
        chk("rst_mid_level", 32'(s_lvl), 32'd0);
`endif
        for (int k = 0; k < 6; k++) cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        chk("rst_mid_emitted", 32'(out_log.size() - base), 32'd0);

        // Randomized traffic against the model; payload held until accepted
        pend = 1'b0;
        r_iv = 1'b0;
        r_id = '0;
        for (int k = 0; k < 800; k++) begin
            logic rr, rf, ro;
            if (!pend) begin
                r_iv = ($urandom_range(0, 3) != 0);
                r_id = 8'($urandom);
            end
            rr = ($urandom_range(0, 99) != 0);
            rf = ($urandom_range(0, 29) == 0);
            ro = ($urandom_range(0, 2) != 0);
            cycle(rr, rf, r_iv, r_id, ro);
            pend = r_iv && !s_acc;
        end
        for (int k = 0; k < 8; k++) cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
